// File: rtl/gf26_mul_arbiter.sv
// gf26_mul_arbiter: round-robin sharing of one GF(2^6) product array with start/ready sequencing and a watchdog
module gf26_mul_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [54*NUM_REQ-1:0] x_in,
  input  logic [48*NUM_REQ-1:0] y_in,
  output logic [NUM_REQ-1:0]    ack,
  output logic [NUM_REQ-1:0]    done,
  output logic [NUM_REQ-1:0]    err,
  output logic [53:0]           z_out,
  output logic                  busy,
  output logic                  fault,
  output logic                  mul_start,
  output logic [53:0]           mul_x,
  output logic [47:0]           mul_y,
  input  logic                  mul_ready,
  input  logic [53:0]           mul_z
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, GAP, HALT} state_t;
  state_t               r_state;
  logic [IW-1:0]        r_last, r_own, w_gnt;
  logic                 w_vld, w_to;
  logic [WW-1:0]        r_wd;
  logic [NUM_REQ-1:0]   r_ack, r_done, r_err, w_oh;
  logic [53:0]          r_z, r_x;
  logic [47:0]          r_y;
  logic                 r_fault, r_start;
  // Nearest set bit after r_last wins; scanning farthest-first lets the nearest overwrite.
  always_comb begin
    w_vld = 1'b0;
    w_gnt = '0;
    for (int k = NUM_REQ; k >= 1; k--)
      if (req[(int'(r_last) + k) % NUM_REQ]) begin
        w_vld = 1'b1;
        w_gnt = IW'((int'(r_last) + k) % NUM_REQ);
      end
  end
  // Watchdog is cleared in ISSUE, so this fires on the TIMEOUT-th cycle after ISSUE.
  assign w_to      = r_wd == WW'(TIMEOUT - 2);
  assign w_oh      = NUM_REQ'(1) << r_own;
  assign busy      = r_state != IDLE;
  assign ack       = r_ack;
  assign done      = r_done;
  assign err       = r_err;
  assign z_out     = r_z;
  assign fault     = r_fault;
  assign mul_start = r_start;
  assign mul_x     = r_x;
  assign mul_y     = r_y;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= IW'(NUM_REQ - 1);
      r_own   <= '0;
      r_wd    <= '0;
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_z     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_fault <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_ack   <= '0;
      r_done  <= '0;
      r_err   <= '0;
      r_start <= 1'b0;
      case (r_state)
        IDLE: if (w_vld && !r_fault) begin
          r_own   <= w_gnt;
          r_last  <= w_gnt;
          r_x     <= x_in[w_gnt*54 +: 54];
          r_y     <= y_in[w_gnt*48 +: 48];
          r_ack   <= NUM_REQ'(1) << w_gnt;
          r_start <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_wd    <= '0;
          r_state <= WAIT_CLR;
        end
        WAIT_CLR, WAIT_DONE: begin
          r_wd <= r_wd + 1'b1;
          if (r_state == WAIT_DONE && mul_ready) begin
            r_z     <= mul_z;
            r_done  <= w_oh;
            r_state <= GAP;
          end else if (w_to) begin
            r_err   <= w_oh;
            r_fault <= 1'b1;
            r_state <= HALT;
          end else if (r_state == WAIT_CLR && !mul_ready) r_state <= WAIT_DONE;
        end
        GAP: r_state <= IDLE;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gf26_mul_arbiter.sv
// tb_gf26_mul_arbiter: directed checks of arbitration, handshake, sticky ready, timeout and reset
module tb_gf26_mul_arbiter;
  localparam logic [53:0] BASE = 54'h2A_AAAA_5555_0F0F;
  logic         clk = 1'b0, reset = 1'b1;
  logic [2:0]   req = '0;
  logic [161:0] x_in;
  logic [143:0] y_in;
  logic [2:0]   ack, done, err;
  logic [53:0]  z_out, mul_x, mul_z;
  logic [47:0]  mul_y;
  logic         busy, fault, mul_start, mul_ready;
  int n_tests = 0, n_fail = 0;
  int lat = 20, clr_dly = 1;
  bit hang = 1'b0;
  int s_cnt = 0;
  bit s_act = 1'b0, s_ps = 1'b0;
  logic s_rdy = 1'b0;
  logic [53:0] s_z = '0;

  gf26_mul_arbiter #(.NUM_REQ(3), .TIMEOUT(50)) dut (
    .clk(clk), .reset(reset), .req(req), .x_in(x_in), .y_in(y_in),
    .ack(ack), .done(done), .err(err), .z_out(z_out), .busy(busy), .fault(fault),
    .mul_start(mul_start), .mul_x(mul_x), .mul_y(mul_y), .mul_ready(mul_ready), .mul_z(mul_z)
  );

  always #5 clk = ~clk;

  // Array stub: edge-detected start, ready drops clr_dly cycles later, rises lat cycles after that
  assign mul_ready = s_rdy;
  assign mul_z     = s_z;
  always @(posedge clk) begin
    if (reset) begin
      s_rdy <= 1'b0; s_act <= 1'b0; s_cnt <= 0; s_ps <= 1'b0;
    end else begin
      s_ps <= mul_start;
      if (mul_start && !s_ps) begin
        s_act <= 1'b1; s_cnt <= 1; s_z <= BASE ^ mul_x ^ {6'b0, mul_y};
      end else if (s_act) begin
        s_cnt <= s_cnt + 1;
        if (s_cnt == clr_dly) s_rdy <= 1'b0;
        if (s_cnt == clr_dly + lat && !hang) begin s_rdy <= 1'b1; s_act <= 1'b0; end
      end
    end
  end

  function automatic logic [53:0] zexp(input int i);
    return BASE ^ x_in[i*54 +: 54] ^ {6'b0, y_in[i*48 +: 48]};
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; req = '0;
    tick; tick;
    n_tests++; if ({ack, done, err} !== 9'b0) begin n_fail++; $display("FAIL reset_pulses got %b want 0", {ack, done, err}); end
    n_tests++; if (z_out !== 54'b0) begin n_fail++; $display("FAIL reset_z got %h want 0", z_out); end
    n_tests++; if ({busy, fault, mul_start} !== 3'b0) begin n_fail++; $display("FAIL reset_flags got %b want 000", {busy, fault, mul_start}); end
    n_tests++; if (mul_x !== 54'b0) begin n_fail++; $display("FAIL reset_mul_x got %h want 0", mul_x); end
    n_tests++; if (mul_y !== 48'b0) begin n_fail++; $display("FAIL reset_mul_y got %h want 0", mul_y); end
    reset = 1'b0;
  endtask

  task automatic test_single;
    int dc = 0, starts = 0, unstable = 0;
    logic [2:0] dv = '0;
    req = 3'b010; tick; req = '0;
    n_tests++; if ({ack, mul_start, busy} !== 5'b01011) begin n_fail++; $display("FAIL single_issue got ack=%b start=%b busy=%b want 010 1 1", ack, mul_start, busy); end
    n_tests++; if (mul_x !== 54'h1 || mul_y !== 48'h1) begin n_fail++; $display("FAIL single_operands got %h/%h want 1/1", mul_x, mul_y); end
    for (int c = 2; c <= 40; c++) begin
      tick;
      if (mul_start) starts++;
      if (dc == 0 && (mul_x !== 54'h1 || mul_y !== 48'h1)) unstable++;
      if (done !== 3'b0 && dc == 0) begin
        dc = c; dv = done;
        n_tests++; if (z_out !== BASE) begin n_fail++; $display("FAIL single_z got %h want %h", z_out, BASE); end
      end
    end
    n_tests++; if (dc != 24) begin n_fail++; $display("FAIL single_done_cycle got %0d want 24", dc); end
    n_tests++; if (dv !== 3'b010) begin n_fail++; $display("FAIL single_done_owner got %b want 010", dv); end
    n_tests++; if (starts != 0) begin n_fail++; $display("FAIL single_extra_start got %0d want 0", starts); end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL single_operand_stable got %0d changes want 0", unstable); end
  endtask

  task automatic test_round_robin;
    int na = 0, nd = 0, c = 0, last_done = -10, own = 0;
    logic [2:0] cur = '0, want;
    reset = 1'b1; tick; reset = 1'b0;
    req = 3'b111;
    while (nd < 6 && c < 400) begin
      tick; c++;
      if (ack !== 3'b0) begin
        na++;
        want = 3'b001 << ((na - 1) % 3);
        n_tests++; if (ack !== want) begin n_fail++; $display("FAIL rr_grant%0d got %b want %b", na, ack, want); end
        if (na > 1) begin
          n_tests++; if (c != last_done + 2) begin n_fail++; $display("FAIL rr_gap%0d got ack at %0d want %0d", na, c, last_done + 2); end
        end
        cur = ack; own = ack[0] ? 0 : ack[1] ? 1 : 2;
      end
      if (done !== 3'b0) begin
        nd++; last_done = c;
        n_tests++; if (done !== cur || mul_start !== 1'b0) begin n_fail++; $display("FAIL rr_done%0d got %b start=%b want %b 0", nd, done, mul_start, cur); end
        n_tests++; if (z_out !== zexp(own)) begin n_fail++; $display("FAIL rr_z%0d got %h want %h", nd, z_out, zexp(own)); end
        if (nd == 6) req = '0;
      end
    end
    n_tests++; if (nd != 6 || na != 6) begin n_fail++; $display("FAIL rr_count got acks=%0d dones=%0d want 6 6", na, nd); end
    repeat (4) tick;
  endtask

  task automatic test_sticky;
    int dc = 0;
    clr_dly = 6;
    req = 3'b001; tick; req = '0;
    n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL sticky_ack got %b want 001", ack); end
    for (int c = 2; c <= 45; c++) begin
      tick;
      if (done !== 3'b0 && dc == 0) dc = c;
    end
    n_tests++; if (dc != 29) begin n_fail++; $display("FAIL sticky_done_cycle got %0d want 29", dc); end
    clr_dly = 1;
  endtask

  task automatic test_withdrawn;
    int a2 = 0, extra = 0, nd = 0;
    logic [2:0] dv = '0;
    req = 3'b001; tick; req = '0;
    for (int c = 2; c <= 60; c++) begin
      tick;
      if (c == 5) req = 3'b100;
      if (c == 6) req = '0;
      if (ack[2]) a2++;
      if (ack !== 3'b0) extra++;
      if (done !== 3'b0) begin nd++; dv = done; end
    end
    n_tests++; if (a2 != 0 || extra != 0) begin n_fail++; $display("FAIL withdrawn_ack got ack2=%0d extra=%0d want 0 0", a2, extra); end
    n_tests++; if (nd != 1 || dv !== 3'b001) begin n_fail++; $display("FAIL withdrawn_done got n=%0d owner=%b want 1 001", nd, dv); end
  endtask

  task automatic test_reset_mid;
    int nd = 0, dc = 0;
    req = 3'b010; tick; req = '0;
    repeat (10) tick;
    reset = 1'b1; tick;
    n_tests++; if ({ack, done, err, busy, fault, mul_start} !== 12'b0) begin n_fail++; $display("FAIL rstmid_flags got %b want 0", {ack, done, err, busy, fault, mul_start}); end
    n_tests++; if (z_out !== 54'b0 || mul_x !== 54'b0 || mul_y !== 48'b0) begin n_fail++; $display("FAIL rstmid_data got %h %h %h want 0", z_out, mul_x, mul_y); end
    reset = 1'b0;
    repeat (30) begin tick; if (done !== 3'b0 || busy) nd++; end
    n_tests++; if (nd != 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d active cycles want 0", nd); end
    req = 3'b111; tick; req = '0;
    n_tests++; if (ack !== 3'b001) begin n_fail++; $display("FAIL rstmid_first_grant got %b want 001", ack); end
    for (int c = 2; c <= 40; c++) begin tick; if (done !== 3'b0 && dc == 0) dc = c; end
    n_tests++; if (dc != 24) begin n_fail++; $display("FAIL rstmid_job_done got %0d want 24", dc); end
  endtask

  task automatic test_timeout;
    int ec = 0, na = 0, ns = 0;
    logic [2:0] ev = '0;
    logic [53:0] zb;
    hang = 1'b1; zb = z_out;
    req = 3'b100; tick; req = '0;
    n_tests++; if (ack !== 3'b100) begin n_fail++; $display("FAIL timeout_ack got %b want 100", ack); end
    for (int c = 2; c <= 80; c++) begin
      tick;
      if (err !== 3'b0 && ec == 0) begin ec = c; ev = err; end
    end
    n_tests++; if (ec != 51) begin n_fail++; $display("FAIL timeout_err_cycle got %0d want 51", ec); end
    n_tests++; if (ev !== 3'b100) begin n_fail++; $display("FAIL timeout_err_owner got %b want 100", ev); end
    n_tests++; if ({fault, busy} !== 2'b11 || z_out !== zb) begin n_fail++; $display("FAIL timeout_state got fault=%b busy=%b z=%h want 1 1 %h", fault, busy, z_out, zb); end
    req = 3'b111;
    repeat (20) begin tick; if (ack !== 3'b0) na++; if (mul_start) ns++; end
    req = '0;
    n_tests++; if (na != 0 || ns != 0) begin n_fail++; $display("FAIL halt_ignores got acks=%0d starts=%0d want 0 0", na, ns); end
    reset = 1'b1; tick; reset = 1'b0; hang = 1'b0;
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear got %b want 0", fault); end
  endtask

  initial begin
    x_in = {54'h3F_FFFF_FFFF_FFFF, 54'h1, 54'h15_0000_0000_0003};
    y_in = {48'hABCD_EF01_2345, 48'h1, 48'h0000_1234_5678};
    test_reset;
    test_single;
    test_round_robin;
    test_sticky;
    test_withdrawn;
    test_reset_mid;
    test_timeout;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gf26_mul_arbiter.md
# gf26_mul_arbiter

Round-robin arbiter and sequencer that shares one `gf26_mul_array` (GF(2^6) 9×8-symbol product engine) among `NUM_REQ` requesters, e.g. encoder, syndrome and Chien-search blocks of the DNA storage controller. It sits between the requesters and the array. It latches one requester's operands, drives the array's edge-detected `start` / sticky `ready_flag` handshake, returns the 54-bit result to the owning requester, and guards every job with a watchdog.

## Interface
Parameters:
- `NUM_REQ`, 3, number of requesters (2..8)
- `TIMEOUT`, 1023, maximum cycles from ISSUE to array ready before fault

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req`  in  NUM_REQ  per-requester level request; held until matching `ack`
- `x_in`  in  54*NUM_REQ  requester i operand X at `[i*54 +: 54]`
- `y_in`  in  48*NUM_REQ  requester i operand Y at `[i*48 +: 48]`
- `ack`  out  NUM_REQ  one-hot, 1-cycle pulse: operands captured
- `done`  out  NUM_REQ  one-hot, 1-cycle pulse: `z_out` valid for that requester
- `err`  out  NUM_REQ  one-hot, 1-cycle pulse: owner's job timed out
- `z_out`  out  54  last captured result, held until next `done`
- `busy`  out  1  high in every state except IDLE
- `fault`  out  1  sticky; set on timeout, cleared only by reset
- `mul_start`  out  1  to array `start`
- `mul_x`  out  54  to array `x`; stable for the whole job
- `mul_y`  out  48  to array `y`; stable for the whole job
- `mul_ready`  in  1  from array `ready_flag`
- `mul_z`  in  54  from array `z`

## Operation
- States: IDLE, ISSUE, WAIT_CLR, WAIT_DONE, GAP, HALT.
- IDLE:
  - If any `req` bit is set and `fault`=0, grant the first set bit searching from `last+1` with wrap-around.
  - Latch the owner index and that requester's X/Y into `mul_x`/`mul_y`, set `last` to the owner, then go to ISSUE.
  - After reset `last`=NUM_REQ-1, so requester 0 wins the first tie.
- ISSUE: `mul_start`=1 for exactly one cycle. Clear the watchdog, then go to WAIT_CLR.
- WAIT_CLR: wait for `mul_ready`=0, which confirms the array accepted the job. Then go to WAIT_DONE.
- WAIT_DONE:
  - On `mul_ready`=1: `z_out`<=`mul_z`, pulse `done[owner]`, go to GAP.
  - A sticky-high `ready_flag` from the previous job never completes a new one, because WAIT_CLR must see 0 first.
- GAP: one cycle with `mul_start`=0. This guarantees the array sees a fresh rising edge on the next job. Then go to IDLE.
- Watchdog:
  - Counts every cycle spent in WAIT_CLR and WAIT_DONE.
  - On reaching `TIMEOUT`: pulse `err[owner]`, set `fault`, go to HALT. `z_out` is unchanged.
  - HALT ignores all `req` and issues no `ack` until reset.
- Request withdrawn before `ack`: allowed and simply ignored. A `req` bit still high in IDLE is treated as a new job, so requesters drop `req` the cycle after `ack` unless they want another product.
- Requests arriving while busy wait; no request is ever lost while it is held.
- `mul_x`/`mul_y` change only on the IDLE→ISSUE edge.

## Timing
- Reset: all outputs 0 (`ack`, `done`, `err`, `z_out`, `busy`, `fault`, `mul_start`, `mul_x`, `mul_y`), state IDLE, `last`=NUM_REQ-1, watchdog 0.
- Cycle T: IDLE samples `req`.
- T+1: ISSUE. `ack[owner]` and `mul_start` are both high this cycle; `busy` is high.
- WAIT_CLR: first cycle is T+2. The array clears `ready_flag` no earlier than T+3.
- Completion: `done` is high the cycle after the edge on which `mul_ready`=1 is sampled in WAIT_DONE. `z_out` is valid in that same cycle.
- Back-to-back throughput: array latency + 4 cycles of overhead (IDLE, ISSUE, WAIT_CLR exit, GAP).
- Reset mid-job: state returns to IDLE immediately and no `done` is emitted. The system resets the array in the same cycle (its `resetN` = ~`reset`).
- Simultaneous `done` and new `req` from the same requester: that request is arbitrated in the next IDLE under normal round-robin.

## Test plan
- Single job:
  - Stimulus: stub array with 20-cycle latency returning 54'h2A_AAAA_5555_0F0F; requester 1 sends x=54'h1, y=48'h1.
  - Required: `ack[1]` at T+1, one `mul_start` pulse, `done[1]` and `z_out`=stub value 23 cycles after ISSUE.
- Round-robin:
  - Stimulus: `req`=3'b111 held continuously.
  - Required: grant order 0,1,2,0,1,2; exactly one `done` per job; GAP cycle with `mul_start`=0 between jobs.
- Sticky ready:
  - Stimulus: stub keeps `mul_ready`=1 after job 1; job 2 issued.
  - Required: no `done` until the stub drops and re-raises `mul_ready`.
- Timeout:
  - Stimulus: `TIMEOUT`=50; stub never raises `mul_ready`.
  - Required: `err[owner]` pulse 50 cycles after ISSUE, `fault`=1, further `req` produce no `ack` until `reset`.
- Reset mid-job:
  - Stimulus: assert `reset` in WAIT_DONE.
  - Required: next cycle all outputs are 0, `busy`=0, no `done`; a new request then grants requester 0 first.
- Withdrawn request:
  - Stimulus: `req[2]` pulsed for one cycle while busy.
  - Required: no `ack[2]` and no job for requester 2.
